interleaver: RTL and testbench
==============================

INTERLEAVER -- requirements
Module: interleaver

Interface
REQ-001 The block SHALL have parameter N_CBPS, default 192, meaning coded bits per OFDM symbol (multiple of 16, max 288).
REQ-002 The block SHALL have parameter N_BPSC, default 4, meaning coded bits per subcarrier; s = max(N_BPSC/2, 1).
REQ-003 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port Input, input, 1 bit, serial coded bit from the convolutional encoder.
REQ-006 The block SHALL have port InValid, input, 1 bit, qualifying Input; the bit is captured on a rising edge with InValid=1.
REQ-007 The block SHALL have port Output, output, 1 bit, serial interleaved bit to the mapper.
REQ-008 The block SHALL have port OutValid, output, 1 bit, high while Output carries a block bit.
REQ-009 The block SHALL have port BlockStart, output, 1 bit, high together with output bit 0 of each block.

Function
REQ-010 Input bit index k (0..N_CBPS-1, k = capture order within block) SHALL go to output position j, where i = (N_CBPS/16)*(k mod 16) + floor(k/16) and j = s*floor(i/s) + (i + N_CBPS - floor(16*i/N_CBPS)) mod s.
REQ-011 Storage SHALL be two N_CBPS-bit banks (ping-pong); the writer fills one bank at address j while the reader drains the other sequentially, position 0 first.
REQ-012 Write addressing SHALL use incremental counters (k mod 16, floor(k/16)); no runtime dividers.
REQ-013 Input gaps (InValid=0) SHALL be allowed anywhere; a block completes on its N_CBPS-th captured bit.
REQ-014 If the last bit of a block is captured at edge t, OutValid SHALL be 1 for the N_CBPS cycles after edges t+1..t+N_CBPS, with Output at position 0..N_CBPS-1 and BlockStart=1 only with position 0.
REQ-015 Once started, the reader SHALL emit one bit per cycle with no gaps until the block is done.
REQ-016 A block completing while the reader drains the other bank SHALL be queued (pending flag); the reader SHALL start it on the cycle after its final bit, giving back-to-back output with OutValid continuously high.
REQ-017 The writer SHALL switch banks on block completion; since the writer rate is at most 1 bit/cycle, overflow cannot occur and needs no flag.
REQ-018 Outside output blocks, Output SHALL be 0, OutValid 0, and BlockStart 0.
REQ-019 Reader state machine: IDLE -> READ on block ready; READ -> READ (next bank) if pending at last position, else READ -> IDLE.

Reset
REQ-020 Reset=0 SHALL immediately force Output=0, OutValid=0, BlockStart=0, the writer counter and bank select to 0, the pending flag to 0, and the FSM to IDLE.
REQ-021 Reset asserted mid-block SHALL discard any partial input block and any output in progress; bank contents need not be cleared.
REQ-022 After Reset returns to 1, the first captured bit SHALL be k=0 of a new block.

Configuration
REQ-023 Macro INTERLEAVER_SECOND_PERM_EN defined: j SHALL be computed per REQ-010 (both permutations).
REQ-024 Macro INTERLEAVER_SECOND_PERM_EN undefined: j SHALL equal i (first permutation only; valid for BPSK/QPSK), and the second-permutation logic SHALL be absent.

Verification
REQ-025 Defaults, single block, only k=1 set -> output block has a single 1 at position 13 (position 12 with the macro undefined).
REQ-026 Defaults, only k=16 set -> single 1 at position 1; only k=0 set -> single 1 at position 0.
REQ-027 Two blocks driven back-to-back without gaps -> OutValid high for 384 consecutive cycles; BlockStart pulses exactly 192 cycles apart.
REQ-028 Block with InValid=0 on every other cycle -> output identical to the ungapped case; output starts the cycle after the 192nd capture.
REQ-029 Reset pulsed low after 100 bits of a block -> no output; the next 192 captured bits form a correct, complete block.
REQ-030 Random 192-bit block through interleaver then DeInterleaver -> the original bits are restored in order.

Source files
------------

// File: rtl/interleaver.sv
// Two-permutation block interleaver with ping-pong bit banks and a serial reader.
// Define INTERLEAVER_SECOND_PERM_EN to enable the second (bit-significance) permutation.
module interleaver #(
  parameter int N_CBPS = 192,
  parameter int N_BPSC = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Input,
  input  logic InValid,
  output logic Output,
  output logic OutValid,
  output logic BlockStart
);

  localparam int STEP = N_CBPS / 16;
  localparam int AW   = $clog2(N_CBPS);
  localparam int DW   = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [AW-1:0] LAST_POS  = AW'(N_CBPS - 1);
  localparam logic [DW-1:0] LAST_KDIV = DW'(STEP - 1);

`ifdef INTERLEAVER_SECOND_PERM_EN
  localparam int S  = (N_BPSC / 2 > 1) ? N_BPSC / 2 : 1;
  localparam int MW = 4;
  localparam logic [MW-1:0] ONE_MOD    = MW'(1 % S);
  localparam logic [MW-1:0] STEP_MOD   = MW'(STEP % S);
  localparam logic [MW-1:0] STEPM1_MOD = MW'((STEP - 1) % S);
  localparam logic [MW-1:0] NCBPS_MOD  = MW'(N_CBPS % S);

  // Adds two residues already below S and folds the result back below S.
  function automatic logic [MW-1:0] mod_add(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (MW+1)'(S)) sum = sum - (MW+1)'(S);
    return sum[MW-1:0];
  endfunction
`endif

  typedef enum logic {S_IDLE, S_READ} state_t;

  // Writer state: k mod 16, floor(k/16) and the first-permutation index i.
  logic [3:0]    kmod_q, kmod_d;
  logic [DW-1:0] kdiv_q, kdiv_d;
  logic [AW-1:0] i_q, i_d;
  logic          wbank_q, wbank_d;
  logic [AW-1:0] waddr;
  logic          blk_done;

`ifdef INTERLEAVER_SECOND_PERM_EN
  // Residues kept incrementally: i mod s, floor(k/16) mod s,
  // (floor(k/16) + N_CBPS) mod s and (i + N_CBPS - k mod 16) mod s.
  logic [MW-1:0] imod_q, imod_d;
  logic [MW-1:0] dmod_q, dmod_d;
  logic [MW-1:0] cmod_q, cmod_d;
  logic [MW-1:0] t_q, t_d;
`endif

  logic [N_CBPS-1:0] bank0_q, bank1_q;

  state_t        state_q;
  logic          rbank_q;
  logic [AW-1:0] raddr_q;
  logic          pending_q;
  logic          out_q, ovld_q, bstart_q;
  logic          rd_bit;

  assign blk_done = InValid && (kmod_q == 4'd15) && (kdiv_q == LAST_KDIV);

`ifdef INTERLEAVER_SECOND_PERM_EN
  // floor(16*i/N_CBPS) is exactly k mod 16, which the t residue already folds in.
  assign waddr = i_q - AW'(imod_q) + AW'(t_q);
`else
  assign waddr = i_q;
`endif

  always_comb begin
    kmod_d  = kmod_q;
    kdiv_d  = kdiv_q;
    i_d     = i_q;
    wbank_d = wbank_q;
`ifdef INTERLEAVER_SECOND_PERM_EN
    imod_d  = imod_q;
    dmod_d  = dmod_q;
    cmod_d  = cmod_q;
    t_d     = t_q;
`endif
    if (InValid) begin
      if (blk_done) begin
        kmod_d  = '0;
        kdiv_d  = '0;
        i_d     = '0;
        wbank_d = ~wbank_q;
`ifdef INTERLEAVER_SECOND_PERM_EN
        imod_d  = '0;
        dmod_d  = '0;
        cmod_d  = NCBPS_MOD;
        t_d     = NCBPS_MOD;
`endif
      end else if (kmod_q == 4'd15) begin
        kmod_d = '0;
        kdiv_d = kdiv_q + 1'b1;
        i_d    = AW'(kdiv_q) + 1'b1;
`ifdef INTERLEAVER_SECOND_PERM_EN
        dmod_d = mod_add(dmod_q, ONE_MOD);
        cmod_d = mod_add(cmod_q, ONE_MOD);
        imod_d = dmod_d;
        t_d    = cmod_d;
`endif
      end else begin
        kmod_d = kmod_q + 1'b1;
        i_d    = i_q + AW'(STEP);
`ifdef INTERLEAVER_SECOND_PERM_EN
        imod_d = mod_add(imod_q, STEP_MOD);
        t_d    = mod_add(t_q, STEPM1_MOD);
`endif
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      kmod_q  <= '0;
      kdiv_q  <= '0;
      i_q     <= '0;
      wbank_q <= 1'b0;
`ifdef INTERLEAVER_SECOND_PERM_EN
      imod_q  <= '0;
      dmod_q  <= '0;
      cmod_q  <= NCBPS_MOD;
      t_q     <= NCBPS_MOD;
`endif
    end else begin
      kmod_q  <= kmod_d;
      kdiv_q  <= kdiv_d;
      i_q     <= i_d;
      wbank_q <= wbank_d;
`ifdef INTERLEAVER_SECOND_PERM_EN
      imod_q  <= imod_d;
      dmod_q  <= dmod_d;
      cmod_q  <= cmod_d;
      t_q     <= t_d;
`endif
    end
  end

  // Bank contents are plain data and survive reset.
  always_ff @(posedge Clock) begin
    if (InValid) begin
      if (wbank_q) bank1_q[waddr] <= Input;
      else         bank0_q[waddr] <= Input;
    end
  end

  assign rd_bit = rbank_q ? bank1_q[raddr_q] : bank0_q[raddr_q];

  // Reader: a completing block arms READ on the capture edge, so position 0
  // appears right after the next edge; a block completing on the final read
  // edge continues without a gap.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      rbank_q   <= 1'b0;
      raddr_q   <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
      ovld_q    <= 1'b0;
      bstart_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_q    <= 1'b0;
          ovld_q   <= 1'b0;
          bstart_q <= 1'b0;
          raddr_q  <= '0;
          if (blk_done) begin
            state_q <= S_READ;
            rbank_q <= wbank_q;
          end
        end
        S_READ: begin
          out_q    <= rd_bit;
          ovld_q   <= 1'b1;
          bstart_q <= (raddr_q == '0);
          if (raddr_q == LAST_POS) begin
            raddr_q <= '0;
            if (pending_q) begin
              rbank_q   <= ~rbank_q;
              pending_q <= 1'b0;
            end else if (blk_done) begin
              rbank_q <= wbank_q;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            raddr_q <= raddr_q + 1'b1;
            if (blk_done) pending_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Output     = out_q;
  assign OutValid   = ovld_q;
  assign BlockStart = bstart_q;

endmodule

// File: tb/tb_interleaver.sv
// Scoreboard bench for interleaver: expected output blocks are queued from a
// reference permutation when each input block completes.
module tb_interleaver;
  localparam int N = 192;

  logic Clock = 1'b0;
  logic Reset, Input, InValid;
  logic Output, OutValid, BlockStart;

  interleaver #(.N_CBPS(N), .N_BPSC(4)) dut (
    .Clock(Clock), .Reset(Reset), .Input(Input), .InValid(InValid),
    .Output(Output), .OutValid(OutValid), .BlockStart(BlockStart)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [1:0] sb_q[$];
  logic [1:0] mon_exp;

  int pos = 0, ones = 0, one_pos = -1, run = 0, max_run = 0;
  int bs_cyc = -1, bs_gap = 0, ov_cnt = 0, last_cap = 0;
  logic out_blk [N];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int jmap(input int k);
    int i, j;
    i = (N / 16) * (k % 16) + k / 16;
`ifdef INTERLEAVER_SECOND_PERM_EN
    j = 2 * (i / 2) + (i + N - (16 * i) / N) % 2;
`else
    j = i;
`endif
    return j;
  endfunction

  task automatic push_expected(input logic [N-1:0] bits);
    logic ob [N];
    for (int k = 0; k < N; k++) ob[jmap(k)] = bits[k];
    for (int p = 0; p < N; p++) sb_q.push_back({ob[p], (p == 0) ? 1'b1 : 1'b0});
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      if (OutValid) begin
        run++;
        if (run > max_run) max_run = run;
        ov_cnt++;
        if (BlockStart) begin
          if (bs_cyc >= 0) bs_gap = cyc - bs_cyc;
          bs_cyc = cyc;
          pos = 0;
        end
        if (pos < N) out_blk[pos] = Output;
        if (Output) begin
          ones++;
          one_pos = pos;
        end
        pos++;
        if (sb_q.size() == 0) begin
          check_val("out_valid_unexpected", {31'd0, OutValid}, 32'd0);
        end else begin
          mon_exp = sb_q.pop_front();
          check_val("out_bit", {31'd0, Output}, {31'd0, mon_exp[1]});
          check_val("block_start", {31'd0, BlockStart}, {31'd0, mon_exp[0]});
        end
      end else begin
        run = 0;
        check_val("idle_zero", {30'd0, BlockStart, Output}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      InValid = 1'b0;
      Input = 1'b0;
    end
  endtask

  task automatic send_block(input logic [N-1:0] bits, input bit gapped);
    for (int k = 0; k < N; k++) begin
      if (gapped) begin
        @(negedge Clock);
        InValid = 1'b0;
        Input = 1'($urandom);
      end
      @(negedge Clock);
      InValid = 1'b1;
      Input = bits[k];
      if (k == N - 1) begin
        last_cap = cyc + 1;
        push_expected(bits);
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(negedge Clock);
      t++;
    end
    check_val("drain", sb_q.size(), 32'd0);
    sb_q.delete();
    idle(2);
  endtask

  task automatic clear_stats();
    ones = 0; one_pos = -1; max_run = 0; bs_cyc = -1; bs_gap = 0; ov_cnt = 0;
  endtask

  function automatic logic [N-1:0] rand_block();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = 1'($urandom);
    return r;
  endfunction

  initial begin
    logic [N-1:0] blk, blk2;
    int exp_k1, errs;
`ifdef INTERLEAVER_SECOND_PERM_EN
    exp_k1 = 13;
`else
    exp_k1 = 12;
`endif
    Reset = 1'b0;
    InValid = 1'b0;
    Input = 1'b0;
    repeat (3) @(negedge Clock);
    check_val("rst_Output", {31'd0, Output}, 32'd0);
    check_val("rst_OutValid", {31'd0, OutValid}, 32'd0);
    check_val("rst_BlockStart", {31'd0, BlockStart}, 32'd0);
    Reset = 1'b1;
    idle(3);

    // Single-one blocks
    clear_stats();
    blk = '0; blk[1] = 1'b1;
    send_block(blk, 1'b0); idle(1); wait_drain();
    check_val("k1_ones", ones, 32'd1);
    check_val("k1_pos", one_pos, exp_k1);
    check_val("k1_latency", bs_cyc, last_cap + 1);

    clear_stats();
    blk = '0; blk[16] = 1'b1;
    send_block(blk, 1'b0); idle(1); wait_drain();
    check_val("k16_ones", ones, 32'd1);
    check_val("k16_pos", one_pos, 32'd1);

    clear_stats();
    blk = '0; blk[0] = 1'b1;
    send_block(blk, 1'b0); idle(1); wait_drain();
    check_val("k0_ones", ones, 32'd1);
    check_val("k0_pos", one_pos, 32'd0);

    // Back-to-back blocks
    clear_stats();
    blk = rand_block(); blk2 = rand_block();
    send_block(blk, 1'b0);
    send_block(blk2, 1'b0);
    idle(1); wait_drain();
    check_val("b2b_run", max_run, 32'd384);
    check_val("b2b_bs_gap", bs_gap, 32'd192);

    // Gapped input
    clear_stats();
    blk = rand_block();
    send_block(blk, 1'b1); idle(1); wait_drain();
    check_val("gap_latency", bs_cyc, last_cap + 1);
    check_val("gap_count", ov_cnt, 32'd192);

    // Reset during output and partial input
    blk = rand_block();
    send_block(blk, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge Clock);
      InValid = 1'b1;
      Input = 1'($urandom);
    end
    @(negedge Clock);
    InValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check_val("rst_mid_OutValid", {31'd0, OutValid}, 32'd0);
    check_val("rst_mid_Output", {31'd0, Output}, 32'd0);
    check_val("rst_mid_BlockStart", {31'd0, BlockStart}, 32'd0);
    sb_q.delete();
    idle(3);
    Reset = 1'b1;
    clear_stats();
    idle(250);
    check_val("no_out_after_rst", ov_cnt, 32'd0);
    clear_stats();
    blk = rand_block();
    send_block(blk, 1'b0); idle(1); wait_drain();
    check_val("post_rst_count", ov_cnt, 32'd192);

    // Round trip through a reference deinterleaver
    blk = rand_block();
    send_block(blk, 1'b0); idle(1); wait_drain();
    errs = 0;
    for (int k = 0; k < N; k++) if (out_blk[jmap(k)] !== blk[k]) errs++;
    check_val("roundtrip_errs", errs, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
